// File: rtl/fp_pkg.sv
// Shared FP32 types, constants and unpack helper for the add/sub datapath.
package fp_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned SIG_W    = FP_MAN_W + 1;
    localparam int unsigned EXT_W    = SIG_W + 3;

    localparam logic [FP_EXP_W-1:0] EXP_INF = 8'hFF;
    localparam logic [31:0]         QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    // Operand after unpacking: class flags plus aligned-ready exponent/significand.
    typedef struct packed {
        logic                is_nan;
        logic                is_snan;
        logic                is_inf;
        logic [FP_EXP_W-1:0] eff_exp;
        logic [SIG_W-1:0]    sig;
    } fp_unpacked_t;

    // Stage-1 payload: ordered operands before the alignment shift.
    typedef struct packed {
        logic                nan;
        logic                snan;
        logic                inf1;
        logic                inf2;
        logic                sign1;
        logic                sign2;
        logic                sign_large;
        logic                swap;
        logic [FP_EXP_W-1:0] shamt;
        logic [FP_EXP_W-1:0] exp_large;
        logic [SIG_W-1:0]    mant_large;
        logic [SIG_W-1:0]    mant_small;
        rm_e                 rm;
    } s1_t;

    // Stage-2 payload: everything the normalize/round stages consume.
    typedef struct packed {
        logic                nan;
        logic                snan;
        logic                inf1;
        logic                inf2;
        logic                sign1;
        logic                sign2;
        logic                sign_large;
        logic                swap;
        logic                eff_sub;
        logic [FP_EXP_W-1:0] exp_large;
        logic [SIG_W-1:0]    mant_large;
        logic [SIG_W-1:0]    mant_small;
        logic [2:0]          grs;
        rm_e                 rm;
    } s2_t;

    // Denormals get an effective exponent of 1 so they align against normals correctly.
    function automatic fp_unpacked_t fp_unpack(input fp32_t x);
        fp_unpacked_t u;
        logic         exp_max;
        logic         frac_nz;
        exp_max   = (x.exp == EXP_INF);
        frac_nz   = (x.frac != '0);
        u.is_nan  = exp_max && frac_nz;
        u.is_snan = exp_max && frac_nz && !x.frac[FP_MAN_W-1];
        u.is_inf  = exp_max && !frac_nz;
        u.eff_exp = (x.exp == '0) ? 8'd1 : x.exp;
        u.sig     = {(x.exp != '0), x.frac};
        return u;
    endfunction

endpackage

// File: rtl/fp_sticky_shifter.sv
// 27-bit right shifter that collapses every shifted-out bit into the sticky bit.
module fp_sticky_shifter
    import fp_pkg::*;
(
    input  logic [23:0] sig_in,
    input  logic [7:0]  shamt,
    output logic [23:0] sig_out,
    output logic [2:0]  grs
);

    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] shifted;
    logic [EXT_W-1:0] lost_mask;
    logic [4:0]       sh;
    logic             lost;

    // Align {sig,G,R,S} and OR together anything that falls off the bottom.
    always_comb begin
        ext       = {sig_in, 3'b000};
        sh        = shamt[4:0];
        shifted   = '0;
        lost_mask = '0;
        lost      = 1'b0;
        sig_out   = '0;
        grs       = '0;
        if (shamt >= 8'd26) begin
            sig_out = '0;
            grs     = {2'b00, |sig_in};
        end else begin
            shifted   = ext >> sh;
            lost_mask = ~({EXT_W{1'b1}} << sh);
            lost      = |(ext & lost_mask);
            sig_out   = shifted[EXT_W-1:3];
            grs       = {shifted[2], shifted[1], shifted[0] | lost};
        end
    end

endmodule

// File: rtl/fadd_extract_align.sv
// FP32 add/sub front end: unpack, classify, order by magnitude and align,
// through a 2-stage valid/ready pipeline.
module fadd_extract_align #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W+MAN_W:0] rs1,
    input  logic [EXP_W+MAN_W:0] rs2,
    input  logic               op_sub,
    input  logic [2:0]         rm_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               NaN,
    output logic               snan,
    output logic               inf1,
    output logic               inf2,
    output logic               sign1,
    output logic               sign2,
    output logic               sign_large,
    output logic               swap,
    output logic               eff_sub,
    output logic [EXP_W-1:0]   exp_large,
    output logic [MAN_W:0]     mant_large,
    output logic [MAN_W:0]     mant_small,
    output logic [2:0]         grs,
    output logic [2:0]         rm_out
);

    import fp_pkg::*;

    fp32_t        op_a;
    fp32_t        op_b;
    fp_unpacked_t ua;
    fp_unpacked_t ub;
    s1_t          s1_d;
    s1_t          s1_q;
    s2_t          s2_d;
    s2_t          s2_q;
    logic         s1_valid;
    logic         s2_valid;
    logic         s1_advance;
    logic         accept;
    logic [23:0]  sh_sig;
    logic [2:0]   sh_grs;

    assign op_a = rs1;
    assign op_b = rs2;

    // Handshake: S1 drains into S2 whenever S2 is empty or being consumed.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;

    // Stage-1 combinational: unpack, classify and order the operands.
    always_comb begin
        s1_d       = '0;
        ua         = fp_unpack(op_a);
        ub         = fp_unpack(op_b);
        s1_d.sign1 = op_a.sign;
        s1_d.sign2 = op_b.sign ^ op_sub;
        s1_d.swap  = ({op_b.exp, op_b.frac} > {op_a.exp, op_a.frac});
        s1_d.nan   = ua.is_nan || ub.is_nan;
        s1_d.snan  = ua.is_snan || ub.is_snan;
        s1_d.inf1  = ua.is_inf;
        s1_d.inf2  = ub.is_inf;
        s1_d.rm    = rm_e'(rm_in);
        if (s1_d.swap) begin
            s1_d.sign_large = s1_d.sign2;
            s1_d.exp_large  = ub.eff_exp;
            s1_d.shamt      = ub.eff_exp - ua.eff_exp;
            s1_d.mant_large = ub.sig;
            s1_d.mant_small = ua.sig;
        end else begin
            s1_d.sign_large = s1_d.sign1;
            s1_d.exp_large  = ua.eff_exp;
            s1_d.shamt      = ua.eff_exp - ub.eff_exp;
            s1_d.mant_large = ua.sig;
            s1_d.mant_small = ub.sig;
        end
    end

    fp_sticky_shifter u_shift (
        .sig_in  (s1_q.mant_small),
        .shamt   (s1_q.shamt),
        .sig_out (sh_sig),
        .grs     (sh_grs)
    );

    // Stage-2 combinational: attach shifter result to the carried fields.
    always_comb begin
        s2_d            = '0;
        s2_d.nan        = s1_q.nan;
        s2_d.snan       = s1_q.snan;
        s2_d.inf1       = s1_q.inf1;
        s2_d.inf2       = s1_q.inf2;
        s2_d.sign1      = s1_q.sign1;
        s2_d.sign2      = s1_q.sign2;
        s2_d.sign_large = s1_q.sign_large;
        s2_d.swap       = s1_q.swap;
        s2_d.eff_sub    = s1_q.sign1 ^ s1_q.sign2;
        s2_d.exp_large  = s1_q.exp_large;
        s2_d.mant_large = s1_q.mant_large;
        s2_d.mant_small = sh_sig;
        s2_d.grs        = sh_grs;
        s2_d.rm         = s1_q.rm;
    end

    // Valid bits: flush kills in-flight ops and wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (s1_advance) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Payload registers: only reset clears them; flush leaves data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (accept) begin
                s1_q <= s1_d;
            end
            if (s1_advance && s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign NaN        = s2_q.nan;
    assign snan       = s2_q.snan;
    assign inf1       = s2_q.inf1;
    assign inf2       = s2_q.inf2;
    assign sign1      = s2_q.sign1;
    assign sign2      = s2_q.sign2;
    assign sign_large = s2_q.sign_large;
    assign swap       = s2_q.swap;
    assign eff_sub    = s2_q.eff_sub;
    assign exp_large  = s2_q.exp_large;
    assign mant_large = s2_q.mant_large;
    assign mant_small = s2_q.mant_small;
    assign grs        = s2_q.grs;
    assign rm_out     = s2_q.rm;

endmodule

// File: tb/tb_fadd_extract_align.sv
// Scoreboard bench for fadd_extract_align using hand-computed directed vectors.
module tb_fadd_extract_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        op_sub;
    logic [2:0]  rm_in;
    logic        out_valid;
    logic        out_ready;
    logic        NaN, snan, inf1, inf2, sign1, sign2;
    logic        sign_large, swap, eff_sub;
    logic [7:0]  exp_large;
    logic [23:0] mant_large, mant_small;
    logic [2:0]  grs, rm_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        op_sub;
        logic [2:0]  rm;
        logic        dp;
        logic        nan, snan, inf1, inf2;
        logic        sign1, sign2, sign_large, swap, eff_sub;
        logic [7:0]  exp_large;
        logic [23:0] ml, ms;
        logic [2:0]  grs;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    fadd_extract_align #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .op_sub(op_sub), .rm_in(rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .NaN(NaN), .snan(snan), .inf1(inf1), .inf2(inf2),
        .sign1(sign1), .sign2(sign2), .sign_large(sign_large),
        .swap(swap), .eff_sub(eff_sub), .exp_large(exp_large),
        .mant_large(mant_large), .mant_small(mant_small),
        .grs(grs), .rm_out(rm_out)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic sub, logic [2:0] rm,
                                logic dp, logic [3:0] flags, logic [4:0] signs,
                                logic [7:0] e, logic [23:0] ml, logic [23:0] ms, logic [2:0] g);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.op_sub = sub; v.rm = rm; v.dp = dp;
        {v.nan, v.snan, v.inf1, v.inf2} = flags;
        {v.sign1, v.sign2, v.sign_large, v.swap, v.eff_sub} = signs;
        v.exp_large = e; v.ml = ml; v.ms = ms; v.grs = g;
        return v;
    endfunction

    // Drive one op and push its expectation once the handshake happens.
    task automatic send(input vec_t v);
        logic rdy;
        logic done;
        done     = 1'b0;
        rs1      = v.rs1;
        rs2      = v.rs2;
        op_sub   = v.op_sub;
        rm_in    = v.rm;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                sb_q.push_back(v);
            end
        end
        #1 in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compare whenever the DUT hands an output over.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("NaN", {31'd0, NaN}, {31'd0, e.nan});
                    chk("snan", {31'd0, snan}, {31'd0, e.snan});
                    chk("inf1", {31'd0, inf1}, {31'd0, e.inf1});
                    chk("inf2", {31'd0, inf2}, {31'd0, e.inf2});
                    chk("sign1", {31'd0, sign1}, {31'd0, e.sign1});
                    chk("sign2", {31'd0, sign2}, {31'd0, e.sign2});
                    chk("eff_sub", {31'd0, eff_sub}, {31'd0, e.eff_sub});
                    chk("rm_out", {29'd0, rm_out}, {29'd0, e.rm});
                    if (e.dp) begin
                        chk("sign_large", {31'd0, sign_large}, {31'd0, e.sign_large});
                        chk("swap", {31'd0, swap}, {31'd0, e.swap});
                        chk("exp_large", {24'd0, exp_large}, {24'd0, e.exp_large});
                        chk("mant_large", {8'd0, mant_large}, {8'd0, e.ml});
                        chk("mant_small", {8'd0, mant_small}, {8'd0, e.ms});
                        chk("grs", {29'd0, grs}, {29'd0, e.grs});
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_flags"}, {28'd0, NaN, snan, inf1, inf2}, 32'd0);
        chk({tag, "_signs"}, {27'd0, sign1, sign2, sign_large, swap, eff_sub}, 32'd0);
        chk({tag, "_exp_large"}, {24'd0, exp_large}, 32'd0);
        chk({tag, "_mant_large"}, {8'd0, mant_large}, 32'd0);
        chk({tag, "_mant_small"}, {8'd0, mant_small}, 32'd0);
        chk({tag, "_grs_rm"}, {26'd0, grs, rm_out}, 32'd0);
    endtask

    initial begin
        logic c_done;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; op_sub = 1'b0; rm_in = '0;

        //              rs1           rs2           sub  rm   dp  {n,s,i1,i2} {s1,s2,sl,sw,es} exp    ml          ms          grs
        vecs.push_back(mk(32'h3FC00000, 32'h3F800000, 1'b0, 3'd0, 1'b1, 4'b0000, 5'b00000, 8'h7F, 24'hC00000, 24'h800000, 3'b000));
        vecs.push_back(mk(32'h40000000, 32'h3F800001, 1'b0, 3'd1, 1'b1, 4'b0000, 5'b00000, 8'h80, 24'h800000, 24'h400000, 3'b100));
        vecs.push_back(mk(32'h3F800000, 32'h30800000, 1'b0, 3'd2, 1'b1, 4'b0000, 5'b00000, 8'h7F, 24'h800000, 24'h000000, 3'b001));
        vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b1, 3'd3, 1'b1, 4'b0000, 5'b01111, 8'h80, 24'h800000, 24'h400000, 3'b000));
        vecs.push_back(mk(32'h7F800001, 32'hFF800000, 1'b0, 3'd4, 1'b0, 4'b1101, 5'b01001, 8'h00, 24'h000000, 24'h000000, 3'b000));
        vecs.push_back(mk(32'h3F800000, 32'h32C00000, 1'b0, 3'd0, 1'b1, 4'b0000, 5'b00000, 8'h7F, 24'h800000, 24'h000000, 3'b001));
        vecs.push_back(mk(32'h3F800000, 32'h33400000, 1'b0, 3'd1, 1'b1, 4'b0000, 5'b00000, 8'h7F, 24'h800000, 24'h000000, 3'b011));
        vecs.push_back(mk(32'h40800000, 32'h3F800003, 1'b0, 3'd2, 1'b1, 4'b0000, 5'b00000, 8'h81, 24'h800000, 24'h200000, 3'b110));
        vecs.push_back(mk(32'h00800000, 32'h00400000, 1'b0, 3'd3, 1'b1, 4'b0000, 5'b00000, 8'h01, 24'h800000, 24'h400000, 3'b000));
        vecs.push_back(mk(32'hBF800000, 32'hBF800000, 1'b1, 3'd4, 1'b1, 4'b0000, 5'b10101, 8'h7F, 24'h800000, 24'h800000, 3'b000));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 1'b0, 3'd0, 1'b1, 4'b0000, 5'b00000, 8'h01, 24'h000000, 24'h000000, 3'b000));
        vecs.push_back(mk(32'h7F800000, 32'h3F800000, 1'b0, 3'd1, 1'b0, 4'b0010, 5'b00000, 8'h00, 24'h000000, 24'h000000, 3'b000));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // Back-to-back stream with the sink always ready.
        foreach (vecs[i]) send(vecs[i]);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_stream", sb_q.size(), 32'd0);
        @(posedge clk); #1;

        // Backpressure: two ops fill the pipe, the third waits.
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        c_done = 1'b0;
        fork
            begin
                send(vecs[2]);
                c_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_exp_large", {24'd0, exp_large}, 32'h7F);
            chk("bp_mant_large", {8'd0, mant_large}, 32'hC00000);
            chk("bp_mant_small", {8'd0, mant_small}, 32'h800000);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 20 && !c_done; i++) @(posedge clk);
        chk("bp_third_accepted", {31'd0, c_done}, 32'd1);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_bp", sb_q.size(), 32'd0);
        @(posedge clk); #1;

        // Flush mid-stream, with a competing input in the flush cycle.
        out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[7]);
        flush    = 1'b1;
        rs1      = vecs[0].rs1;
        rs2      = vecs[0].rs2;
        op_sub   = 1'b0;
        rm_in    = 3'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.delete();
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_dropped", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Reset mid-stream.
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[9]);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        sb_q.delete();
        @(posedge clk); #1 out_ready = 1'b1;

        // Pipe still works after the reset.
        send(vecs[7]);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_final", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
